// File: rtl/ghash_ctrl.sv
// GHASH sequencer for AES-GCM. Folds each AAD/ciphertext block into the
// running hash Y by issuing Y <- (Y ^ block) * H to an external bit-serial
// GF(2^128) multiplier. Finishes with the {len(A), len(C)} block and
// presents the result to the tag stage.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no message open; waits for iInit with a loaded key
// WAIT     | message open; accepts a block or the final length block
// MUL      | block product in flight; operands held on the multiplier
// MUL_LEN  | length-block product in flight
// DONE     | publishes Y as the GHASH value, then returns to IDLE
module ghash_ctrl #(
  parameter int unsigned MUL_TIMEOUT = 255
) (
  input  logic         iClk,
  input  logic         iRstn,
  input  logic         iInit,
  input  logic [0:127] iHashkey,
  input  logic         iHashkey_valid,
  input  logic [0:127] iBlock,
  input  logic         iBlock_valid,
  input  logic         iFinal_valid,
  input  logic [63:0]  iLen_a,
  input  logic [63:0]  iLen_c,
  output logic         oReady,
  output logic [0:127] oMul_ctext,
  output logic [0:127] oMul_hashkey,
  output logic         oMul_valid,
  input  logic [0:127] iMul_result,
  input  logic         iMul_result_valid,
  output logic [0:127] oGhash,
  output logic         oGhash_valid,
  output logic         oBusy,
  output logic         oErr
);

  localparam int unsigned TW = (MUL_TIMEOUT < 2) ? 1 : $clog2(MUL_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(MUL_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_MUL,
    S_MUL_LEN,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [0:127]  y_q;
  logic [0:127]  x_q;
  logic [0:127]  h_q;
  logic          key_loaded_q;
  logic          mul_valid_q;
  logic [0:127]  ghash_q;
  logic          ghash_valid_q;
  logic          err_q;
  logic [TW-1:0] tmo_q;
  logic          init_take;

  // An iInit in IDLE only opens a message once a key is present; while
  // busy it always restarts the message.
  assign init_take = iInit && ((state_q != S_IDLE) || key_loaded_q);

  // Hash key register; frozen while a product is in flight so the H
  // operand never changes under the multiplier.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      h_q          <= '0;
      key_loaded_q <= 1'b0;
    end else if (iHashkey_valid && !mul_valid_q) begin
      h_q          <= iHashkey;
      key_loaded_q <= 1'b1;
    end
  end

  // Message sequencer with registered multiplier handshake, timeout
  // down-counter and result publication.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q       <= S_IDLE;
      y_q           <= '0;
      x_q           <= '0;
      mul_valid_q   <= 1'b0;
      ghash_q       <= '0;
      ghash_valid_q <= 1'b0;
      err_q         <= 1'b0;
      tmo_q         <= '0;
    end else begin
      ghash_valid_q <= 1'b0;
      if (init_take) begin
        // A result landing on this same cycle is deliberately dropped.
        y_q         <= '0;
        err_q       <= 1'b0;
        mul_valid_q <= 1'b0;
        state_q     <= S_WAIT;
      end else begin
        case (state_q)
          S_IDLE: begin
          end
          S_WAIT: begin
            if (iBlock_valid) begin
              x_q         <= y_q ^ iBlock;
              mul_valid_q <= 1'b1;
              tmo_q       <= TMO_LOAD;
              state_q     <= S_MUL;
            end else if (iFinal_valid) begin
              x_q         <= y_q ^ {iLen_a, iLen_c};
              mul_valid_q <= 1'b1;
              tmo_q       <= TMO_LOAD;
              state_q     <= S_MUL_LEN;
            end
          end
          S_MUL, S_MUL_LEN: begin
            if (iMul_result_valid) begin
              y_q         <= iMul_result;
              mul_valid_q <= 1'b0;
              state_q     <= (state_q == S_MUL) ? S_WAIT : S_DONE;
            end else if (tmo_q == TMO_LAST) begin
              err_q       <= 1'b1;
              mul_valid_q <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              tmo_q <= tmo_q - TMO_LAST;
            end
          end
          S_DONE: begin
            ghash_q       <= y_q;
            ghash_valid_q <= 1'b1;
            state_q       <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign oReady       = (state_q == S_WAIT);
  assign oBusy        = (state_q != S_IDLE);
  assign oMul_ctext   = x_q;
  assign oMul_hashkey = h_q;
  assign oMul_valid   = mul_valid_q;
  assign oGhash       = ghash_q;
  assign oGhash_valid = ghash_valid_q;
  assign oErr         = err_q;

endmodule

// File: tb/tb_ghash_ctrl.sv
// Bench for ghash_ctrl: a behavioural GF(2^128) multiplier responder plus a
// software GHASH model drive directed and randomized messages.
module tb_ghash_ctrl;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         init = 1'b0;
  logic [127:0] hk = '0;
  logic         hk_v = 1'b0;
  logic [127:0] blk = '0;
  logic         blk_v = 1'b0;
  logic         fin_v = 1'b0;
  logic [63:0]  la = '0;
  logic [63:0]  lc = '0;
  logic         rdy;
  logic [127:0] mctext;
  logic [127:0] mhk;
  logic         mval;
  logic [127:0] mres;
  logic         mres_v;
  logic [127:0] gh;
  logic         ghv;
  logic         busy;
  logic         err;

  int total = 0;
  int bad = 0;

  // multiplier responder / monitor state
  bit           resp_off = 1'b0;
  int           lat = 3;
  logic         resp_v = 1'b0;
  logic [127:0] resp_r = '0;
  logic         man_v = 1'b0;
  logic [127:0] man_r = '0;
  bit           active = 1'b0;
  int           rcnt = 0;
  logic [127:0] cap_x = '0;
  logic [127:0] cap_h = '0;
  int           stab_bad = 0;
  int           ovl_bad = 0;
  int           issues = 0;
  int           ghv_cnt = 0;

  logic [127:0] ref_blks[$];

  assign mres_v = resp_v | man_v;
  assign mres   = man_v ? man_r : resp_r;

  always #5 clk = ~clk;

  ghash_ctrl dut (
    .iClk(clk), .iRstn(rstn), .iInit(init),
    .iHashkey(hk), .iHashkey_valid(hk_v),
    .iBlock(blk), .iBlock_valid(blk_v), .iFinal_valid(fin_v),
    .iLen_a(la), .iLen_c(lc), .oReady(rdy),
    .oMul_ctext(mctext), .oMul_hashkey(mhk), .oMul_valid(mval),
    .iMul_result(mres), .iMul_result_valid(mres_v),
    .oGhash(gh), .oGhash_valid(ghv), .oBusy(busy), .oErr(err)
  );

  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [127:0] ghash_ref(input logic [127:0] h, input logic [63:0] a,
                                             input logic [63:0] c);
    logic [127:0] y;
    y = '0;
    foreach (ref_blks[i]) y = gf_mul(y ^ ref_blks[i], h);
    return gf_mul(y ^ {a, c}, h);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Multiplier model with operand-stability and ready/valid overlap checks.
  initial begin
    forever begin
      @(negedge clk);
      resp_v = 1'b0;
      if (ghv) ghv_cnt++;
      if (rdy && mval) ovl_bad++;
      if (mval) begin
        if (!active) begin
          active = 1'b1;
          issues++;
          rcnt = 0;
          cap_x = mctext;
          cap_h = mhk;
        end else if (mctext !== cap_x || mhk !== cap_h) begin
          stab_bad++;
        end
        rcnt++;
        if (!resp_off && rcnt == lat) begin
          resp_r = gf_mul(cap_x, cap_h);
          resp_v = 1'b1;
        end
      end else begin
        active = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    init = 0; hk_v = 0; blk_v = 0; fin_v = 0; man_v = 0; resp_off = 0;
    rstn = 0;
    tick(2);
    rstn = 1;
    tick(1);
  endtask

  task automatic load_key(input logic [127:0] h);
    hk = h; hk_v = 1;
    tick(1);
    hk_v = 0;
  endtask

  task automatic start_msg();
    init = 1;
    tick(1);
    init = 0;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      total++; bad++;
      $display("FAIL %s: oReady never rose within 2000 cycles", nm);
    end
  endtask

  task automatic send_block(input logic [127:0] b);
    wait_ready("send_block");
    blk = b; blk_v = 1;
    tick(1);
    blk_v = 0;
  endtask

  task automatic send_final(input logic [63:0] a, input logic [63:0] c);
    wait_ready("send_final");
    la = a; lc = c; fin_v = 1;
    tick(1);
    fin_v = 0;
  endtask

  task automatic wait_ghash(input string nm, output logic [127:0] g);
    int n;
    n = 0;
    g = '0;
    while (!ghv && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!ghv) begin
      total++; bad++;
      $display("FAIL %s: no oGhash_valid within 3000 cycles", nm);
    end else begin
      g = gh;
    end
  endtask

  task automatic test_reset();
    rstn = 1;
    #2 rstn = 0;
    #2;
    total++; if (rdy !== 1'b0)    begin bad++; $display("FAIL rst_ready got=%b exp=0", rdy); end
    total++; if (mval !== 1'b0)   begin bad++; $display("FAIL rst_mul_valid got=%b exp=0", mval); end
    total++; if (mctext !== '0)   begin bad++; $display("FAIL rst_ctext got=%h exp=0", mctext); end
    total++; if (mhk !== '0)      begin bad++; $display("FAIL rst_hashkey got=%h exp=0", mhk); end
    total++; if (gh !== '0)       begin bad++; $display("FAIL rst_ghash got=%h exp=0", gh); end
    total++; if (ghv !== 1'b0)    begin bad++; $display("FAIL rst_ghash_valid got=%b exp=0", ghv); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (err !== 1'b0)    begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    tick(2);
    rstn = 1;
    tick(1);
    start_msg();
    tick(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL init_no_key busy got=%b exp=0", busy); end
  endtask

  task automatic test_empty();
    logic [127:0] g;
    int g0;
    do_reset();
    lat = 2;
    load_key(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    start_msg();
    g0 = ghv_cnt;
    send_final(64'h0, 64'h0);
    wait_ghash("empty", g);
    total++; if (g !== 128'h0) begin bad++; $display("FAIL empty ghash got=%h exp=0", g); end
    tick(5);
    total++; if (ghv_cnt - g0 !== 1) begin bad++; $display("FAIL empty pulses got=%0d exp=1", ghv_cnt - g0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL empty busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_identity();
    logic [127:0] g;
    do_reset();
    lat = 4;
    load_key(128'h80000000_00000000_00000000_00000000);
    start_msg();
    send_block(128'h0388dace60b6a392f328c2b971b2fe78);
    send_final(64'd0, 64'd128);
    wait_ghash("identity", g);
    total++;
    if (g !== 128'h0388dace60b6a392f328c2b971b2fef8) begin
      bad++; $display("FAIL identity ghash got=%h exp=0388dace60b6a392f328c2b971b2fef8", g);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] h, g, exp;
    logic [63:0]  a, c;
    do_reset();
    lat = 3;
    h = rand128();
    a = {$urandom, $urandom};
    c = {$urandom, $urandom};
    ref_blks.delete();
    for (int i = 0; i < 3; i++) ref_blks.push_back(rand128());
    exp = ghash_ref(h, a, c);
    load_key(h);
    start_msg();
    stab_bad = 0; ovl_bad = 0; issues = 0;
    send_block(ref_blks[0]);
    total++; if (mval !== 1'b1) begin bad++; $display("FAIL b2b issue_latency mul_valid got=%b exp=1", mval); end
    total++; if (mctext !== ref_blks[0]) begin bad++; $display("FAIL b2b first_x got=%h exp=%h", mctext, ref_blks[0]); end
    // key update attempted mid-product must be ignored
    hk = ~h; hk_v = 1;
    tick(1);
    hk_v = 0;
    send_block(ref_blks[1]);
    send_block(ref_blks[2]);
    send_final(a, c);
    wait_ghash("b2b", g);
    total++; if (g !== exp) begin bad++; $display("FAIL b2b ghash got=%h exp=%h", g, exp); end
    total++; if (stab_bad !== 0) begin bad++; $display("FAIL b2b operand_stability changes=%0d exp=0", stab_bad); end
    total++; if (ovl_bad !== 0) begin bad++; $display("FAIL b2b ready_valid_overlap cycles=%0d exp=0", ovl_bad); end
    total++; if (issues !== 4) begin bad++; $display("FAIL b2b mul_issues got=%0d exp=4", issues); end
  endtask

  task automatic test_random();
    logic [127:0] h, g, exp;
    logic [63:0]  a, c;
    int nb;
    do_reset();
    for (int m = 0; m < 5; m++) begin
      lat = $urandom_range(1, 6);
      nb = $urandom_range(0, 4);
      h = rand128();
      a = {$urandom, $urandom};
      c = {$urandom, $urandom};
      ref_blks.delete();
      for (int i = 0; i < nb; i++) ref_blks.push_back(rand128());
      exp = ghash_ref(h, a, c);
      load_key(h);
      start_msg();
      for (int i = 0; i < nb; i++) send_block(ref_blks[i]);
      send_final(a, c);
      wait_ghash("random", g);
      total++; if (g !== exp) begin bad++; $display("FAIL random msg%0d ghash got=%h exp=%h", m, g, exp); end
      tick(2);
    end
  endtask

  task automatic test_simultaneous();
    logic [127:0] h, b, g, exp;
    logic [63:0]  a, c;
    int n;
    do_reset();
    lat = 2;
    h = rand128();
    b = rand128();
    a = {$urandom, $urandom};
    c = {$urandom, $urandom};
    ref_blks.delete();
    ref_blks.push_back(b);
    exp = ghash_ref(h, a, c);
    load_key(h);
    start_msg();
    issues = 0;
    wait_ready("simul");
    blk = b; blk_v = 1; la = a; lc = c; fin_v = 1;
    tick(1);
    blk_v = 0;
    total++; if (mctext !== b) begin bad++; $display("FAIL simul block_first x got=%h exp=%h", mctext, b); end
    n = 0;
    while (!rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tick(1);
    fin_v = 0;
    wait_ghash("simul", g);
    total++; if (g !== exp) begin bad++; $display("FAIL simul ghash got=%h exp=%h", g, exp); end
    total++; if (issues !== 2) begin bad++; $display("FAIL simul mul_issues got=%0d exp=2", issues); end
  endtask

  task automatic test_timeout();
    int n, g0;
    do_reset();
    load_key(rand128());
    start_msg();
    resp_off = 1;
    send_block(rand128());
    n = 0;
    while (!err && n < 600) begin
      if (mval) n++;
      @(negedge clk);
    end
    total++; if (n !== 255) begin bad++; $display("FAIL timeout cycles got=%0d exp=255", n); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL timeout err got=%b exp=1", err); end
    total++; if (mval !== 1'b0) begin bad++; $display("FAIL timeout mul_valid got=%b exp=0", mval); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout busy got=%b exp=0", busy); end
    g0 = ghv_cnt;
    man_r = rand128(); man_v = 1;
    tick(1);
    man_v = 0;
    tick(3);
    total++; if (busy !== 1'b0 || ghv_cnt !== g0) begin
      bad++; $display("FAIL timeout late_result busy=%b pulses=%0d exp busy=0 pulses=0", busy, ghv_cnt - g0);
    end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL timeout err_sticky got=%b exp=1", err); end
    start_msg();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL timeout err_clear got=%b exp=0", err); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL timeout reinit_ready got=%b exp=1", rdy); end
    resp_off = 0;
  endtask

  task automatic test_abort();
    logic [127:0] h, g, exp;
    logic [63:0]  a, c;
    int g0;
    do_reset();
    h = rand128();
    a = {$urandom, $urandom};
    c = {$urandom, $urandom};
    ref_blks.delete();
    exp = ghash_ref(h, a, c);
    load_key(h);
    start_msg();
    resp_off = 1;
    send_block(rand128());
    tick(3);
    total++; if (mval !== 1'b1) begin bad++; $display("FAIL abort mul_active got=%b exp=1", mval); end
    g0 = ghv_cnt;
    init = 1; man_r = rand128() | 128'h1; man_v = 1;
    tick(1);
    init = 0; man_v = 0;
    total++; if (mval !== 1'b0) begin bad++; $display("FAIL abort mul_valid got=%b exp=0", mval); end
    total++; if (rdy !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL abort wait_state ready=%b busy=%b exp 1 1", rdy, busy);
    end
    resp_off = 0;
    lat = 2;
    send_final(a, c);
    wait_ghash("abort", g);
    total++; if (g !== exp) begin bad++; $display("FAIL abort y_cleared ghash got=%h exp=%h", g, exp); end
    tick(3);
    total++; if (ghv_cnt - g0 !== 1) begin bad++; $display("FAIL abort pulses got=%0d exp=1", ghv_cnt - g0); end
    // asynchronous reset in the middle of a product
    resp_off = 1;
    start_msg();
    send_block(rand128());
    tick(2);
    rstn = 0;
    #1;
    total++; if ({rdy, mval, ghv, busy, err} !== 5'b0) begin
      bad++; $display("FAIL midrst flags ready=%b mval=%b gval=%b busy=%b err=%b exp all 0", rdy, mval, ghv, busy, err);
    end
    total++; if (mctext !== '0 || mhk !== '0 || gh !== '0) begin
      bad++; $display("FAIL midrst data ctext=%h hk=%h ghash=%h exp 0", mctext, mhk, gh);
    end
    tick(2);
    rstn = 1;
    resp_off = 0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_identity();
    test_back_to_back();
    test_random();
    test_simultaneous();
    test_timeout();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ghash_ctrl.md
Name: ghash_ctrl

Overview:
- GHASH sequencer for the AES-GCM datapath, and the initiator side of the bit-serial GF(2^128) multiplier interface.
- Accepts AAD/ciphertext blocks over valid/ready, computes X = Y ^ block, and issues each product Y <- X·H to an external multiplier.
- Holds the operands stable until the result returns, then folds in the final {len(A), len(C)} block and emits the 128-bit GHASH value to the tag stage.

Parameters:
- MUL_TIMEOUT, 255, maximum cycles to wait for iMul_result_valid before flagging oErr and aborting to IDLE.

Ports:
- iClk  input  1  clock.
- iRstn  input  1  asynchronous active-low reset.
- iInit  input  1  start new message: clears Y, aborts any operation in flight.
- iHashkey  input  [0:127]  H = E_K(0^128).
- iHashkey_valid  input  1  load H into the internal key register.
- iBlock  input  [0:127]  AAD or ciphertext block, zero-padded by the upstream stage.
- iBlock_valid  input  1  block offered.
- iFinal_valid  input  1  message complete; iLen_a and iLen_c are valid.
- iLen_a  input  64  AAD bit length.
- iLen_c  input  64  ciphertext bit length.
- oReady  output  1  block or final accepted this cycle when valid & oReady.
- oMul_ctext  output  [0:127]  X operand to the multiplier.
- oMul_hashkey  output  [0:127]  H operand to the multiplier.
- oMul_valid  output  1  drives both multiplier valid inputs (ctext and hashkey).
- iMul_result  input  [0:127]  product from the multiplier.
- iMul_result_valid  input  1  product valid (single-cycle pulse).
- oGhash  output  [0:127]  final GHASH value.
- oGhash_valid  output  1  one-cycle pulse.
- oBusy  output  1  a message is open (state != IDLE).
- oErr  output  1  sticky timeout flag; cleared by iInit.

Behaviour:
- Reset values: all outputs 0; Y = 0; H register = 0; key_loaded = 0; state IDLE.
- H register loads on any cycle with iHashkey_valid, except while oMul_valid = 1 (load ignored); key_loaded is set on load.
- States:
  - IDLE: oReady = 0. iInit & key_loaded -> WAIT (Y <= 0, oErr <= 0). iInit without a loaded key stays in IDLE.
  - WAIT: oReady = 1.
    - iBlock_valid -> X <= Y ^ iBlock; go MUL.
    - Else iFinal_valid -> X <= Y ^ {iLen_a, iLen_c}; go MUL_LEN.
    - Block has priority on a simultaneous offer; the final stays pending and is taken on a later WAIT cycle.
  - MUL / MUL_LEN: oMul_valid = 1, oReady = 0. oMul_ctext = X and oMul_hashkey = H, both held stable the entire time.
    - On the cycle iMul_result_valid is sampled: Y <= iMul_result; oMul_valid is 0 from the next cycle.
    - MUL -> WAIT.
    - MUL_LEN -> DONE.
  - DONE: oGhash <= Y, oGhash_valid = 1 for exactly one cycle, then IDLE. oGhash holds its value until the next DONE.
- Latency:
  - oMul_valid rises on the cycle after acceptance.
  - oReady is back the cycle after the result is sampled.
  - With the 128-step bit-serial multiplier attached, expect about 131 cycles per block.
- Multiplier contract: oMul_valid stays continuously high from issue until the result. It never drops mid-operation except on abort, because the multiplier step counter only advances while valid.
- Timeout: a counter runs in MUL/MUL_LEN.
  - On reaching MUL_TIMEOUT: oErr <= 1, oMul_valid <= 0, go IDLE.
  - A late result pulse is ignored.
- iInit while busy:
  - Any state: Y <= 0, go WAIT, oMul_valid <= 0.
  - A result arriving on the same cycle is discarded.
  - An iInit during MUL/MUL_LEN is only safe if the multiplier's step counter clears itself (it does on overflow). Upstream must not re-issue until the pending result pulse has passed. This is documented as a system constraint, not checked.
- Reset mid-operation: immediate return to reset values. No output pulse.
- Empty message (no blocks, lengths 0): X = 0, result 0, oGhash = 0.
- Bit order: index 0 = MSB = coefficient x^0 (GCM convention). The length block is iLen_a in [0:63] and iLen_c in [64:127].

Test Plan:
- Empty message: load H = 66e94bd4ef8a2c3b884cfa59ca342b2e, iInit, then final with lengths 0 -> oGhash = 0, one oGhash_valid pulse.
- Identity key: H = 80000000_00000000_00000000_00000000, one block B = 0388dace60b6a392f328c2b971b2fe78, final len_a = 0, len_c = 128 -> oGhash = B ^ 0x00..0080 = 0388dace60b6a392f328c2b971b2fef8.
- Back-to-back: 3 blocks plus final with a fixed-latency multiplier model. Check:
  - Operands stay stable under oMul_valid.
  - oReady never overlaps oMul_valid.
  - Result matches the software GHASH model.
- Simultaneous iBlock_valid and iFinal_valid in WAIT -> block consumed first; final consumed in the next WAIT; result is correct.
- Timeout: model never returns a result -> oErr = 1 after MUL_TIMEOUT cycles, state IDLE, oMul_valid = 0; the next iInit clears oErr.
- Abort: iInit mid-MUL on the same cycle as iMul_result_valid -> result ignored, Y = 0, WAIT, no oGhash_valid. Also assert iRstn low mid-MUL -> all outputs 0.
